// File: rtl/bp_resolve_unit.sv
// Branch resolve unit: queues fetch predictions in order, checks them against EX outcomes,
// and drives flush/redirect and predictor updates. Optional perf counters: BP_RESOLVE_PERF_EN.
module bp_resolve_unit #(
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid_i,
  input  logic [31:0]         push_pc_i,
  input  logic                push_taken_i,
  input  logic [31:0]         push_target_i,
  output logic                full_o,
  output logic                empty_o,
  input  logic                resolve_valid_i,
  input  logic                resolve_is_branch_i,
  input  logic                resolve_taken_i,
  input  logic [31:0]         resolve_target_i,
  output logic                flush_o,
  output logic [31:0]         redirect_pc_o,
  output logic                update_en_o,
  output logic [31:0]         update_pc_o,
  output logic                update_taken_o,
  output logic [31:0]         update_target_o,
  output logic                err_o,
  output logic [CNT_BITS-1:0] branch_cnt_o,
  output logic [CNT_BITS-1:0] mispredict_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;

  logic        flush_reg;
  logic [31:0] redirect_pc_reg;
  logic        update_en_reg;
  logic [31:0] update_pc_reg;
  logic        update_taken_reg;
  logic [31:0] update_target_reg;
  logic        err_reg;

  logic [31:0] head_pc;
  logic        head_taken;
  logic [31:0] head_target;
  logic        resolve_fire;
  logic        mispredict;
  logic        branch_fire;
  logic        push_accept;
  logic        err_set;
  logic [31:0] redirect_pc_next;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign head_pc     = pc_mem[rd_ptr_reg[AW-1:0]];
  assign head_taken  = taken_mem[rd_ptr_reg[AW-1:0]];
  assign head_target = target_mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    resolve_fire     = resolve_valid_i && !empty_o;
    mispredict       = 1'b0;
    branch_fire      = resolve_fire && resolve_is_branch_i;
    redirect_pc_next = head_pc + 32'd4;
    if (resolve_fire) begin
      if (resolve_is_branch_i) begin
        mispredict = (resolve_taken_i != head_taken) ||
                     (resolve_taken_i && (resolve_target_i != head_target));
      end else begin
        mispredict = head_taken;
      end
    end
    if (resolve_is_branch_i && resolve_taken_i) begin
      redirect_pc_next = resolve_target_i;
    end

    // A correct pop frees a slot this cycle; a flush makes any push wrong-path.
    push_accept = push_valid_i && !mispredict && (!full_o || resolve_fire);
    err_set     = (push_valid_i && full_o && !resolve_fire) ||
                  (resolve_valid_i && empty_o);

    rd_ptr_next = resolve_fire ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;
    if (mispredict) begin
      wr_ptr_next = rd_ptr_next;
    end else if (push_accept) begin
      wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    end else begin
      wr_ptr_next = wr_ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (push_accept) begin
      pc_mem[wr_ptr_reg[AW-1:0]]     <= push_pc_i;
      taken_mem[wr_ptr_reg[AW-1:0]]  <= push_taken_i;
      target_mem[wr_ptr_reg[AW-1:0]] <= push_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      flush_reg         <= 1'b0;
      redirect_pc_reg   <= '0;
      update_en_reg     <= 1'b0;
      update_pc_reg     <= '0;
      update_taken_reg  <= 1'b0;
      update_target_reg <= '0;
      err_reg           <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      flush_reg     <= mispredict;
      update_en_reg <= branch_fire;
      if (mispredict) begin
        redirect_pc_reg <= redirect_pc_next;
      end
      if (branch_fire) begin
        update_pc_reg     <= head_pc;
        update_taken_reg  <= resolve_taken_i;
        update_target_reg <= resolve_target_i;
      end
      if (err_set) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign flush_o         = flush_reg;
  assign redirect_pc_o   = redirect_pc_reg;
  assign update_en_o     = update_en_reg;
  assign update_pc_o     = update_pc_reg;
  assign update_taken_o  = update_taken_reg;
  assign update_target_o = update_target_reg;
  assign err_o           = err_reg;

`ifdef BP_RESOLVE_PERF_EN
  logic [CNT_BITS-1:0] branch_cnt_reg;
  logic [CNT_BITS-1:0] mispredict_cnt_reg;

  // Saturating counters: they stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (branch_fire && (branch_cnt_reg != '1)) begin
        branch_cnt_reg <= branch_cnt_reg + CNT_BITS'(1);
      end
      if (mispredict && (mispredict_cnt_reg != '1)) begin
        mispredict_cnt_reg <= mispredict_cnt_reg + CNT_BITS'(1);
      end
    end
  end

  assign branch_cnt_o     = branch_cnt_reg;
  assign mispredict_cnt_o = mispredict_cnt_reg;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Self-checking bench for bp_resolve_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_bp_resolve_unit;

  localparam int DEPTH    = 4;
  localparam int CNT_BITS = 32;
`ifdef BP_RESOLVE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                push_valid_i;
  logic [31:0]         push_pc_i;
  logic                push_taken_i;
  logic [31:0]         push_target_i;
  logic                full_o;
  logic                empty_o;
  logic                resolve_valid_i;
  logic                resolve_is_branch_i;
  logic                resolve_taken_i;
  logic [31:0]         resolve_target_i;
  logic                flush_o;
  logic [31:0]         redirect_pc_o;
  logic                update_en_o;
  logic [31:0]         update_pc_o;
  logic                update_taken_o;
  logic [31:0]         update_target_o;
  logic                err_o;
  logic [CNT_BITS-1:0] branch_cnt_o;
  logic [CNT_BITS-1:0] mispredict_cnt_o;

  bp_resolve_unit #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_pc_i(push_pc_i),
    .push_taken_i(push_taken_i), .push_target_i(push_target_i),
    .full_o(full_o), .empty_o(empty_o),
    .resolve_valid_i(resolve_valid_i), .resolve_is_branch_i(resolve_is_branch_i),
    .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .update_en_o(update_en_o), .update_pc_o(update_pc_o),
    .update_taken_o(update_taken_o), .update_target_o(update_target_o),
    .err_o(err_o), .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  // Reference model state.
  entry_t      m_q[$];
  bit          m_err;
  int unsigned m_bcnt, m_mcnt;
  bit          exp_flush, exp_upd_en, exp_upd_taken;
  logic [31:0] exp_redirect, exp_upd_pc, exp_upd_target;

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    m_q.delete();
    m_err = 0; m_bcnt = 0; m_mcnt = 0;
    exp_flush = 0; exp_upd_en = 0;
  endtask

  // Drives one cycle of stimulus and advances the model; returns #1 after the edge.
  task automatic step(input bit pv, input logic [31:0] ppc, input bit ptk, input logic [31:0] ptgt,
                      input bit rv, input bit rb, input bit rtk, input logic [31:0] rtgt);
    entry_t h;
    bit mis;
    mis = 0;
    push_valid_i = pv; push_pc_i = ppc; push_taken_i = ptk; push_target_i = ptgt;
    resolve_valid_i = rv; resolve_is_branch_i = rb; resolve_taken_i = rtk; resolve_target_i = rtgt;
    exp_flush = 0; exp_upd_en = 0;
    if (rv) begin
      if (m_q.size() == 0) begin
        m_err = 1;
      end else begin
        h = m_q.pop_front();
        mis = rb ? ((rtk != h.taken) || (rtk && rtgt != h.target)) : h.taken;
        if (rb) begin
          exp_upd_en = 1; exp_upd_pc = h.pc; exp_upd_taken = rtk; exp_upd_target = rtgt;
          m_bcnt++;
        end
        if (mis) begin
          exp_flush = 1;
          exp_redirect = (rb && rtk) ? rtgt : h.pc + 32'd4;
          m_q.delete();
          m_mcnt++;
        end
      end
    end
    if (pv && !mis) begin
      if (m_q.size() < DEPTH) m_q.push_back('{ppc, ptk, ptgt});
      else m_err = 1;
    end
    @(posedge clk); #1;
    $display("txn t=%0t push=%0b pc=%h ptk=%0b res=%0b br=%0b tk=%0b tgt=%h -> flush=%0b upd=%0b",
             $time, pv, ppc, ptk, rv, rb, rtk, rtgt, flush_o, update_en_o);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    push_valid_i = 0; push_pc_i = 0; push_taken_i = 0; push_target_i = 0;
    resolve_valid_i = 0; resolve_is_branch_i = 0; resolve_taken_i = 0; resolve_target_i = 0;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks += 8;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      errors++; $display("FAIL reset_ptr: empty=%b full=%b, expected empty=1 full=0", empty_o, full_o);
    end
    if (flush_o !== 1'b0 || update_en_o !== 1'b0) begin
      errors++; $display("FAIL reset_pulse: flush=%b upd=%b, expected 0 0", flush_o, update_en_o);
    end
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h expected 0", redirect_pc_o); end
    if (update_pc_o !== 32'h0) begin errors++; $display("FAIL reset_upd_pc: got %h expected 0", update_pc_o); end
    if (update_taken_o !== 1'b0) begin errors++; $display("FAIL reset_upd_taken: got %b expected 0", update_taken_o); end
    if (update_target_o !== 32'h0) begin errors++; $display("FAIL reset_upd_target: got %h expected 0", update_target_o); end
    if (branch_cnt_o !== '0 || mispredict_cnt_o !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_correct_branch();
    do_reset();
    step(1, 32'h100, 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 32'h0);
    checks += 3;
    if (update_en_o !== 1'b1 || update_pc_o !== 32'h100) begin
      errors++; $display("FAIL correct_upd: en=%b pc=%h expected en=1 pc=00000100", update_en_o, update_pc_o);
    end
    if (flush_o !== 1'b0) begin errors++; $display("FAIL correct_flush: got %b expected 0", flush_o); end
    if (empty_o !== 1'b1) begin errors++; $display("FAIL correct_empty: got %b expected 1", empty_o); end
    idle();
    checks++;
    if (update_en_o !== 1'b0) begin errors++; $display("FAIL correct_pulse_len: upd=%b expected 0", update_en_o); end
  endtask

  task automatic test_target_mispredict();
    do_reset();
    step(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 32'h340);
    checks += 3;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL tgt_flush: got %b expected 1", flush_o); end
    if (redirect_pc_o !== 32'h340) begin errors++; $display("FAIL tgt_redirect: got %h expected 00000340", redirect_pc_o); end
    if (update_target_o !== 32'h340 || update_en_o !== 1'b1) begin
      errors++; $display("FAIL tgt_update: en=%b tgt=%h expected en=1 tgt=00000340", update_en_o, update_target_o);
    end
  endtask

  task automatic test_not_branch_flush();
    do_reset();
    step(1, 32'h10, 1, 32'h80, 0, 0, 0, 0);
    step(1, 32'h14, 0, 32'h0, 0, 0, 0, 0);
    step(1, 32'h18, 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    checks += 4;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL nb_flush: got %b expected 1", flush_o); end
    if (redirect_pc_o !== 32'h14) begin errors++; $display("FAIL nb_redirect: got %h expected 00000014", redirect_pc_o); end
    if (update_en_o !== 1'b0) begin errors++; $display("FAIL nb_upd: got %b expected 0", update_en_o); end
    if (empty_o !== 1'b1) begin errors++; $display("FAIL nb_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_full();
    logic [31:0] want [4];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h1000 + 32'(4 * i), 0, 32'h0, 0, 0, 0, 0);
      checks++;
      if (full_o !== (i >= 3)) begin
        errors++; $display("FAIL full_flag[%0d]: got %b expected %b", i, full_o, (i >= 3));
      end
    end
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL full_err: got %b expected 1", err_o); end
    step(1, 32'h2000, 0, 32'h0, 1, 1, 0, 32'h0);
    checks += 2;
    if (full_o !== 1'b1) begin errors++; $display("FAIL full_pushpop: full=%b expected 1", full_o); end
    if (update_pc_o !== 32'h1000 || flush_o !== 1'b0) begin
      errors++; $display("FAIL full_pushpop_upd: pc=%h flush=%b expected 00001000 0", update_pc_o, flush_o);
    end
    want[0] = 32'h1004; want[1] = 32'h1008; want[2] = 32'h100c; want[3] = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1, 0, 32'h0);
      checks++;
      if (update_en_o !== 1'b1 || update_pc_o !== want[i]) begin
        errors++; $display("FAIL full_drain[%0d]: en=%b pc=%h expected 1 %h", i, update_en_o, update_pc_o, want[i]);
      end
    end
    checks++;
    if (empty_o !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_flush_with_push();
    do_reset();
    step(1, 32'h40, 1, 32'h80, 0, 0, 0, 0);
    step(1, 32'h50, 0, 32'h0, 1, 1, 0, 32'h0);
    checks += 3;
    if (flush_o !== 1'b1 || redirect_pc_o !== 32'h44) begin
      errors++; $display("FAIL fp_flush: flush=%b redirect=%h expected 1 00000044", flush_o, redirect_pc_o);
    end
    if (empty_o !== 1'b1) begin errors++; $display("FAIL fp_empty: got %b expected 1", empty_o); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL fp_err: got %b expected 0", err_o); end
    step(1, 32'h60, 0, 32'h0, 0, 0, 0, 0);
    checks++;
    if (empty_o !== 1'b0) begin errors++; $display("FAIL fp_push_after: empty=%b expected 0", empty_o); end
    step(0, 0, 0, 0, 1, 1, 0, 32'h0);
    checks++;
    if (update_pc_o !== 32'h60) begin errors++; $display("FAIL fp_next_pc: got %h expected 00000060", update_pc_o); end
    step(0, 0, 0, 0, 1, 1, 0, 32'h0);
    checks += 2;
    if (err_o !== 1'b1) begin errors++; $display("FAIL empty_resolve_err: got %b expected 1", err_o); end
    if (update_en_o !== 1'b0 || flush_o !== 1'b0) begin
      errors++; $display("FAIL empty_resolve_pulse: upd=%b flush=%b expected 0 0", update_en_o, flush_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 32'h300, 0, 32'h0, 0, 0, 0, 0);
    step(1, 32'h304, 1, 32'h500, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 32'h0);
    checks++;
    if (update_en_o !== 1'b1 || update_pc_o !== 32'h300) begin
      errors++; $display("FAIL b2b_first: en=%b pc=%h expected 1 00000300", update_en_o, update_pc_o);
    end
    step(0, 0, 0, 0, 1, 1, 1, 32'h500);
    checks++;
    if (update_en_o !== 1'b1 || update_pc_o !== 32'h304 || update_taken_o !== 1'b1 || flush_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second: en=%b pc=%h tk=%b flush=%b expected 1 00000304 1 0",
                         update_en_o, update_pc_o, update_taken_o, flush_o);
    end
    idle();
    checks++;
    if (update_en_o !== 1'b0) begin errors++; $display("FAIL b2b_end: en=%b expected 0", update_en_o); end
  endtask

  task automatic test_perf_and_reset();
    do_reset();
    step(1, 32'h700, 0, 32'h0, 0, 0, 0, 0);
    step(1, 32'h704, 1, 32'h900, 1, 1, 0, 32'h0);
    step(1, 32'h708, 0, 32'h0, 1, 1, 1, 32'h900);
    step(0, 0, 0, 0, 1, 1, 1, 32'hA00);
    checks += 2;
    if (branch_cnt_o !== (PERF ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL perf_branch: got %0d expected %0d", branch_cnt_o, PERF ? 3 : 0);
    end
    if (mispredict_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL perf_mispredict: got %0d expected %0d", mispredict_cnt_o, PERF ? 1 : 0);
    end
    step(1, 32'h800, 1, 32'h880, 0, 0, 0, 0);
    step(1, 32'h804, 0, 32'h0, 0, 0, 0, 0);
    // Reset in the same cycle as a mispredicting resolve: no pulse may follow.
    rst = 1;
    push_valid_i = 0; resolve_valid_i = 1; resolve_is_branch_i = 1;
    resolve_taken_i = 0; resolve_target_i = 0;
    @(posedge clk); #1;
    rst = 0; resolve_valid_i = 0;
    model_clear();
    checks += 3;
    if (flush_o !== 1'b0 || update_en_o !== 1'b0) begin
      errors++; $display("FAIL midrst_pulse: flush=%b upd=%b expected 0 0", flush_o, update_en_o);
    end
    if (empty_o !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty_o); end
    if (branch_cnt_o !== '0 || mispredict_cnt_o !== '0) begin
      errors++; $display("FAIL midrst_cnt: got %0d/%0d expected 0/0", branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_random();
    bit pv, ptk, rv, rb, rtk;
    logic [31:0] ppc, ptgt, rtgt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pv   = ($urandom_range(0, 99) < 60);
      ppc  = 32'($urandom_range(0, 255)) << 2;
      ptk  = $urandom_range(0, 1);
      ptgt = ($urandom_range(0, 1) != 0) ? 32'h400 : 32'h500;
      rv   = ($urandom_range(0, 99) < 45);
      rb   = ($urandom_range(0, 99) < 75);
      rtk  = $urandom_range(0, 1);
      rtgt = ($urandom_range(0, 1) != 0) ? 32'h400 : 32'h500;
      step(pv, ppc, ptk, ptgt, rv, rb, rtk, rtgt);
      checks += 5;
      if (flush_o !== exp_flush || (exp_flush && redirect_pc_o !== exp_redirect)) begin
        errors++; $display("FAIL rand_flush[%0d]: flush=%b pc=%h expected %b %h",
                           n, flush_o, redirect_pc_o, exp_flush, exp_redirect);
      end
      if (update_en_o !== exp_upd_en || (exp_upd_en && (update_pc_o !== exp_upd_pc ||
          update_taken_o !== exp_upd_taken || update_target_o !== exp_upd_target))) begin
        errors++; $display("FAIL rand_update[%0d]: en=%b pc=%h tk=%b tgt=%h expected %b %h %b %h", n,
                           update_en_o, update_pc_o, update_taken_o, update_target_o,
                           exp_upd_en, exp_upd_pc, exp_upd_taken, exp_upd_target);
      end
      if (empty_o !== (m_q.size() == 0) || full_o !== (m_q.size() == DEPTH)) begin
        errors++; $display("FAIL rand_level[%0d]: empty=%b full=%b expected occupancy %0d",
                           n, empty_o, full_o, m_q.size());
      end
      if (err_o !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", n, err_o, m_err); end
      if (branch_cnt_o !== (PERF ? m_bcnt : 0) || mispredict_cnt_o !== (PERF ? m_mcnt : 0)) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, branch_cnt_o,
                           mispredict_cnt_o, PERF ? m_bcnt : 0, PERF ? m_mcnt : 0);
      end
    end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_correct_branch();
    test_target_mispredict();
    test_not_branch_flush();
    test_full();
    test_flush_with_push();
    test_back_to_back();
    test_perf_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
